rect_plotter: RTL and testbench
===============================

// Module: rect_plotter
// PURPOSE
//  Parametrised rectangle rasteriser for the VGA adapter path. On a start pulse it latches
//  origin, size, colour and mode, then emits one pixel per clk (xout/yout/colourout/plot),
//  row-major. Supports filled and outline modes, screen clipping, abort and a start/busy/done handshake.
//  Replaces the fixed 4x4 square drawers; game FSM muxes its outputs onto the adapter.
// PARAMETERS
//  X_W       12   x coordinate width (xpos, xout)
//  Y_W       11   y coordinate width (ypos, yout)
//  SZ_W      7    width/height field width; max rectangle side 2**SZ_W-1
//  SCREEN_W  160  pixels with x >= SCREEN_W are clipped (plot=0)
//  SCREEN_H  120  pixels with y >= SCREEN_H are clipped (plot=0)
// PORTS
//  clk        in   1     system clock, single clock domain
//  reset      in   1     synchronous, active-high reset
//  start      in   1     begin a rectangle; sampled only in IDLE
//  abort      in   1     terminate current rectangle; no done pulse
//  xpos       in   X_W   top-left x, latched on accepted start
//  ypos       in   Y_W   top-left y, latched on accepted start
//  width      in   SZ_W  columns, latched on accepted start
//  height     in   SZ_W  rows, latched on accepted start
//  colourin   in   3     RGB colour, latched on accepted start
//  mode       in   1     0 = FILL, 1 = OUTLINE; latched on accepted start
//  busy       out  1     high from accepted start until done/abort
//  done       out  1     one-cycle pulse after final pixel
//  xout       out  X_W   pixel x (registered)
//  yout       out  Y_W   pixel y (registered)
//  colourout  out  3     pixel colour (registered)
//  plot       out  1     write strobe for the VGA adapter (registered)
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, plot=0, xout=0, yout=0, colourout=0; counters cleared.
//  - FSM: IDLE -> (start & !abort) -> SCAN -> (last pixel emitted) -> FIN -> IDLE.
//    FIN lasts exactly one cycle and drives done=1.
//    abort in SCAN or FIN -> IDLE next edge, plot=0, done=0.
//    abort in IDLE has no effect; start is ignored.
//  - start accepted at edge N: busy=1 after N; first pixel (xpos,ypos) on outputs after N+1.
//    Pixel k appears after N+1+k. Last pixel index P-1 appears after N+P.
//    done=1 and busy=0 after N+P+1.
//  - start while busy: ignored, inputs not re-latched. Inputs may change freely after acceptance.
//  - Scan: col 0..W-1 inner, row 0..H-1 outer. xout = x0+col, yout = y0+row.
//  - OUTLINE: on interior rows (0<row<H-1), col jumps 0 -> W-1, so interior pixels consume no cycles.
//    P = W*H when H<=2 or W<=2, else 2W + 2(H-2).
//    FILL: P = W*H.
//  - Zero size (width==0 or height==0): start accepted, no pixel, SCAN skipped.
//    done after N+1, busy high one cycle.
//  - Clipping: sums computed at X_W+1 / Y_W+1 bits. Clipped pixels hold plot=0 and
//    still consume their cycle, so latency is unchanged. Coordinates never wrap.
//  - plot=0 in IDLE and FIN; xout/yout/colourout hold last value when plot=0.
//  - Reset mid-SCAN: same as power-on reset next edge, no done.
// STRUCTURE
//  - gfx_pkg (shared): X_W/Y_W defaults, SCREEN_W/H, colour constants (BLACK=3'b000,
//    RED=3'b100, WHITE=3'b111), MODE_FILL/MODE_OUTLINE, FSM state encoding.
//  - Sub-module rect_scan_counter: col/row counters with load, outline skip and a
//    last-pixel flag. Top holds FSM, latches, clip compare and output registers.
// TESTING
//  1 FILL x=122,y=18,w=4,h=4,c=100 -> 16 plots, (122,18)..(125,21) row-major, done after edge N+17.
//  2 OUTLINE x=10,y=10,w=5,h=4 -> 14 plots, no (11..13,11..12), done after N+15; busy 14+1 cycles.
//  3 FILL x=158,y=118,w=4,h=3 -> 12 cycles, plot=1 only for x<160,y<120 (4 pixels), done after N+13.
//  4 w=0,h=9 start -> no plot, done after N+1; second start during SCAN of a 4x4 ignored, count stays 16.
//  5 abort after 5th pixel of 8x8 FILL -> plot=0 and busy=0 next edge, done never pulses, new start accepted.
//  6 reset asserted mid-SCAN -> all outputs 0 next edge; back-to-back starts on done cycle accepted in IDLE.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared graphics definitions for the VGA adapter path.
// Holds default coordinate/size widths, the visible screen extent,
// colour constants, rectangle draw modes and the rasteriser FSM encoding.
package gfx_pkg;

    localparam int X_W_DEF      = 12;
    localparam int Y_W_DEF      = 11;
    localparam int SZ_W_DEF     = 7;
    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] WHITE = 3'b111;

    localparam logic MODE_FILL    = 1'b0;
    localparam logic MODE_OUTLINE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIN  = 2'd2
    } rect_state_t;

endpackage

// File: rtl/rect_scan_counter.sv
// Column/row walker for the rectangle rasteriser.
// Walks col 0..W-1 (inner) and row 0..H-1 (outer). In outline mode, interior
// rows jump straight from col 0 to col W-1 so skipped pixels take no cycles.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_load              restart at (0,0)
//   i_adv               step to the next pixel
//   i_outline           outline mode select
//   i_width, i_height   latched rectangle size
//   o_col, o_row        current pixel position within the rectangle
//   o_last              current position is the final pixel
module rect_scan_counter #(
    parameter int SZ_W = 7
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_load,
    input  logic            i_adv,
    input  logic            i_outline,
    input  logic [SZ_W-1:0] i_width,
    input  logic [SZ_W-1:0] i_height,
    output logic [SZ_W-1:0] o_col,
    output logic [SZ_W-1:0] o_row,
    output logic            o_last
);

    logic [SZ_W-1:0] r_col;
    logic [SZ_W-1:0] r_row;
    logic [SZ_W-1:0] w_wm1;
    logic [SZ_W-1:0] w_hm1;
    logic            w_col_end;
    logic            w_interior;

    assign w_wm1      = i_width  - SZ_W'(1);
    assign w_hm1      = i_height - SZ_W'(1);
    assign w_col_end  = (r_col == w_wm1);
    assign w_interior = (r_row != '0) && (r_row != w_hm1);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_load) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_adv) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + SZ_W'(1);
            end else if (i_outline && w_interior && (r_col == '0)) begin
                // Left edge of an interior row: the next pixel is the right edge.
                r_col <= w_wm1;
            end else begin
                r_col <= r_col + SZ_W'(1);
            end
        end
    end

    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_last = w_col_end && (r_row == w_hm1);

endmodule

// File: rtl/rect_plotter.sv
// Rectangle rasteriser: latches origin/size/colour/mode on an accepted start
// and emits one pixel per clock, row-major, with screen clipping.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, abort        begin (IDLE only) / terminate current rectangle
//   xpos, ypos          top-left corner
//   width, height       rectangle size
//   colourin, mode      pixel colour, FILL(0)/OUTLINE(1)
//   busy, done          handshake: busy while scanning, one-cycle done pulse
//   xout, yout          registered pixel coordinate
//   colourout, plot     registered pixel colour and write strobe
module rect_plotter
    import gfx_pkg::*;
#(
    parameter int X_W      = X_W_DEF,
    parameter int Y_W      = Y_W_DEF,
    parameter int SZ_W     = SZ_W_DEF,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [X_W-1:0]  xpos,
    input  logic [Y_W-1:0]  ypos,
    input  logic [SZ_W-1:0] width,
    input  logic [SZ_W-1:0] height,
    input  logic [2:0]      colourin,
    input  logic            mode,
    output logic            busy,
    output logic            done,
    output logic [X_W-1:0]  xout,
    output logic [Y_W-1:0]  yout,
    output logic [2:0]      colourout,
    output logic            plot
);

    localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

    rect_state_t     r_state;
    rect_state_t     w_next;

    logic [X_W-1:0]  r_x0;
    logic [Y_W-1:0]  r_y0;
    logic [SZ_W-1:0] r_w;
    logic [SZ_W-1:0] r_h;
    logic [2:0]      r_colour;
    logic            r_mode;
    // Set once every pixel has been put on the outputs (or at start for an
    // empty rectangle); SCAN then hands over to FIN on the following edge.
    logic            r_drained;

    logic [X_W-1:0]  r_xout;
    logic [Y_W-1:0]  r_yout;
    logic [2:0]      r_cout;
    logic            r_plot;

    logic            w_accept;
    logic            w_emit;
    logic [SZ_W-1:0] w_col;
    logic [SZ_W-1:0] w_row;
    logic            w_last;
    logic [X_W:0]    w_xsum;
    logic [Y_W:0]    w_ysum;
    logic            w_on_screen;

    assign w_accept = (r_state == ST_IDLE) && start && !abort;
    assign w_emit   = (r_state == ST_SCAN) && !abort && !r_drained;

    rect_scan_counter #(.SZ_W(SZ_W)) u_scan (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_load    (w_accept),
        .i_adv     ((r_state == ST_SCAN) && !r_drained),
        .i_outline (r_mode == MODE_OUTLINE),
        .i_width   (r_w),
        .i_height  (r_h),
        .o_col     (w_col),
        .o_row     (w_row),
        .o_last    (w_last)
    );

    // One extra bit so an off-screen sum is clipped instead of wrapping.
    assign w_xsum      = {1'b0, r_x0} + (X_W+1)'(w_col);
    assign w_ysum      = {1'b0, r_y0} + (Y_W+1)'(w_row);
    assign w_on_screen = (w_xsum < SCR_W) && (w_ysum < SCR_H);

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_SCAN;
            ST_SCAN: begin
                if (abort)          w_next = ST_IDLE;
                else if (r_drained) w_next = ST_FIN;
            end
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        busy = (r_state == ST_SCAN);
        done = (r_state == ST_FIN);
    end

    // Operand latches: only written on an accepted start
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_x0     <= xpos;
            r_y0     <= ypos;
            r_w      <= width;
            r_h      <= height;
            r_colour <= colourin;
            r_mode   <= mode;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_drained <= 1'b0;
        else if (w_accept)
            r_drained <= (width == '0) || (height == '0);
        else if (w_emit && w_last)
            r_drained <= 1'b1;
    end

    // Pixel output registers; coordinates hold while plot is low
    always_ff @(posedge clk) begin
        if (reset) begin
            r_plot <= 1'b0;
            r_xout <= '0;
            r_yout <= '0;
            r_cout <= BLACK;
        end else if (w_emit) begin
            r_plot <= w_on_screen;
            if (w_on_screen) begin
                r_xout <= w_xsum[X_W-1:0];
                r_yout <= w_ysum[Y_W-1:0];
                r_cout <= r_colour;
            end
        end else begin
            r_plot <= 1'b0;
        end
    end

    assign plot      = r_plot;
    assign xout      = r_xout;
    assign yout      = r_yout;
    assign colourout = r_cout;

endmodule

// File: tb/tb_rect_plotter.sv
module tb_rect_plotter;
    import gfx_pkg::*;

    localparam int X_W  = 12;
    localparam int Y_W  = 11;
    localparam int SZ_W = 7;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [X_W-1:0]  xpos = '0;
    logic [Y_W-1:0]  ypos = '0;
    logic [SZ_W-1:0] width = '0;
    logic [SZ_W-1:0] height = '0;
    logic [2:0]      colourin = '0;
    logic            mode = 1'b0;
    logic            busy, done, plot;
    logic [X_W-1:0]  xout;
    logic [Y_W-1:0]  yout;
    logic [2:0]      colourout;

    rect_plotter #(
        .X_W(X_W), .Y_W(Y_W), .SZ_W(SZ_W), .SCREEN_W(160), .SCREEN_H(120)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .xpos(xpos), .ypos(ypos), .width(width), .height(height),
        .colourin(colourin), .mode(mode),
        .busy(busy), .done(done), .xout(xout), .yout(yout),
        .colourout(colourout), .plot(plot)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    function automatic void chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // On acceptance the whole pixel list is enumerated from the rectangle
    // definition; afterwards one list entry is consumed per clock.
    typedef struct {
        int x;
        int y;
        bit vis;
    } pix_t;

    pix_t q[$];
    int   m_phase = 0;   // 0 idle, 1 busy, 2 done pulse
    bit   m_plot  = 1'b0;
    int   m_x = 0, m_y = 0, m_c = 0, m_col = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_plot = 0; m_x = 0; m_y = 0; m_c = 0;
            q.delete();
        end else begin
            case (m_phase)
                0: begin
                    m_plot = 0;
                    if (start && !abort) begin
                        q.delete();
                        for (int r = 0; r < int'(height); r++)
                            for (int c = 0; c < int'(width); c++)
                                if (!mode || r == 0 || r == int'(height) - 1 ||
                                    c == 0 || c == int'(width) - 1)
                                    q.push_back('{x: int'(xpos) + c, y: int'(ypos) + r,
                                                  vis: (int'(xpos) + c < 160) && (int'(ypos) + r < 120)});
                        m_col   = int'(colourin);
                        m_phase = 1;
                    end
                end
                1: begin
                    if (abort) begin
                        m_phase = 0; m_plot = 0; q.delete();
                    end else if (q.size() == 0) begin
                        m_phase = 2; m_plot = 0;
                    end else begin
                        pix_t p;
                        p = q.pop_front();
                        m_plot = p.vis;
                        if (p.vis) begin
                            m_x = p.x; m_y = p.y; m_c = m_col;
                        end
                    end
                end
                default: begin
                    m_phase = 0; m_plot = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("plot",   int'(plot),      int'(m_plot));
            chk("busy",   int'(busy),      int'(m_phase == 1));
            chk("done",   int'(done),      int'(m_phase == 2));
            chk("xout",   int'(xout),      m_x);
            chk("yout",   int'(yout),      m_y);
            chk("colour", int'(colourout), m_c);
        end
    end

    // ---------------- directed runs ----------------
    int s_plots, s_busy, s_done, s_fx, s_fy, s_lx, s_ly, s_int;

    // k counts negedges after the accepting edge N (k=0 is just after N).
    task automatic run_rect(input int x, input int y, input int w, input int h,
                            input int c, input bit m, input int ab_k, input int rs_k);
        s_plots = 0; s_busy = 0; s_done = -1;
        s_fx = -1; s_fy = -1; s_lx = -1; s_ly = -1; s_int = 0;
        @(negedge clk);
        xpos = X_W'(x); ypos = Y_W'(y); width = SZ_W'(w); height = SZ_W'(h);
        colourin = 3'(c); mode = m; start = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (k == 0) begin
                // operands may change freely after acceptance
                xpos = X_W'(7); ypos = Y_W'(3); width = SZ_W'(2); height = SZ_W'(2);
                colourin = WHITE;
            end
            if (plot) begin
                if (s_plots == 0) begin s_fx = int'(xout); s_fy = int'(yout); end
                s_lx = int'(xout); s_ly = int'(yout);
                s_plots++;
                if (xout >= 11 && xout <= 13 && yout >= 11 && yout <= 12) s_int++;
            end
            if (busy) s_busy++;
            if (done) begin s_done = k; break; end
            abort = (k == ab_k);
            if (k == rs_k) begin
                start = 1'b1; xpos = X_W'(60); ypos = Y_W'(60);
                width = SZ_W'(8); height = SZ_W'(8);
            end else begin
                start = 1'b0;
            end
            if (ab_k >= 0 && k > ab_k && !busy) break;
        end
        start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_xout", int'(xout), 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: FILL 4x4 red near right edge, fully visible
        run_rect(122, 18, 4, 4, 3'b100, MODE_FILL, -1, -1);
        chk("t1_plots", s_plots, 16);
        chk("t1_done",  s_done, 17);
        chk("t1_first_x", s_fx, 122); chk("t1_first_y", s_fy, 18);
        chk("t1_last_x",  s_lx, 125); chk("t1_last_y",  s_ly, 21);

        // 2: OUTLINE 5x4, interior never drawn
        run_rect(10, 10, 5, 4, 3'b010, MODE_OUTLINE, -1, -1);
        chk("t2_plots", s_plots, 14);
        chk("t2_interior", s_int, 0);
        chk("t2_done", s_done, 15);
        chk("t2_busy", s_busy, 15);

        // 3: clipped corner rectangle
        run_rect(158, 118, 4, 3, 3'b111, MODE_FILL, -1, -1);
        chk("t3_plots", s_plots, 4);
        chk("t3_done",  s_done, 13);
        chk("t3_last_x", s_lx, 159); chk("t3_last_y", s_ly, 119);

        // 4: zero width, then restart attempt during a 4x4 scan
        run_rect(30, 30, 0, 9, 3'b001, MODE_FILL, -1, -1);
        chk("t4_zero_plots", s_plots, 0);
        chk("t4_zero_done",  s_done, 1);
        chk("t4_zero_busy",  s_busy, 1);
        run_rect(20, 30, 4, 4, 3'b011, MODE_FILL, -1, 3);
        chk("t4_restart_plots", s_plots, 16);
        chk("t4_restart_done",  s_done, 17);

        // abort/start together in IDLE: nothing happens
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        chk("idle_abort_busy", int'(busy), 0);
        start = 1'b0; abort = 1'b0;

        // 5: abort after 5th pixel, then a new start (2x2 outline)
        run_rect(40, 40, 8, 8, 3'b101, MODE_FILL, 5, -1);
        chk("t5_plots", s_plots, 5);
        chk("t5_no_done", s_done, -1);
        chk("t5_busy_after_abort", int'(busy), 0);
        chk("t5_plot_after_abort", int'(plot), 0);
        run_rect(0, 0, 2, 2, 3'b110, MODE_OUTLINE, -1, -1);
        chk("t5_new_plots", s_plots, 4);
        chk("t5_new_done",  s_done, 5);

        // 6: reset mid-scan
        @(negedge clk);
        xpos = X_W'(5); ypos = Y_W'(5); width = SZ_W'(8); height = SZ_W'(8);
        colourin = RED; mode = MODE_FILL; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_plot", int'(plot), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_done", int'(done), 0);
        chk("t6_rst_xout", int'(xout), 0);
        chk("t6_rst_yout", int'(yout), 0);
        chk("t6_rst_colour", int'(colourout), 0);
        reset = 1'b0;
        @(negedge clk);

        // 6b: start held through done is accepted once back in IDLE
        xpos = X_W'(1); ypos = Y_W'(1); width = SZ_W'(3); height = SZ_W'(3);
        colourin = WHITE; mode = MODE_FILL; start = 1'b1;
        s_done = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) begin s_done = k; break; end
        end
        chk("t6_first_done", s_done, 10);
        @(negedge clk);
        chk("t6_fin_to_idle_busy", int'(busy), 0);
        @(negedge clk);
        chk("t6_reaccept_busy", int'(busy), 1);
        start = 1'b0;
        s_done = -1;
        for (int k = 1; k < 60; k++) begin
            @(negedge clk);
            if (done) begin s_done = k; break; end
        end
        chk("t6_second_done", s_done, 10);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
